countdown16: RTL and testbench
==============================

// Module: countdown16
// PURPOSE
//   Loadable down-counter/timer built on a combinational decrementer (dec16, y = a - 1).
//   Software-visible delay and loop-count engine beside the Hack PC.
//   Counts a loaded value down to zero, then raises a one-cycle done pulse.
//   Optional auto-reload turns it into a periodic tick source.
// PARAMETERS
//   WIDTH        16  counter, load and reload register width (dec16 is instantiated at 16)
//   AUTO_RELOAD  0   0 = stop in IDLE after done; 1 = reload from reload_reg and rerun
// PORTS
//   clk       in   1      single clock, rising edge
//   rst_n     in   1      asynchronous, active-low reset
//   load      in   1      load load_val into count and reload_reg; aborts any run
//   load_val  in   WIDTH  value to load
//   start     in   1      begin countdown from the current count (sampled in IDLE only)
//   hold      in   1      freeze the decrement while in RUN
//   count     out  WIDTH  current counter value (registered)
//   busy      out  1      1 while state == RUN
//   done      out  1      1 while state == DONE (registered, normally one cycle)
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE, count=0, reload_reg=0, busy=0, done=0.
//     Asserting reset mid-run clears everything immediately; there is no resume.
//   - Priority at every edge: rst_n > load > state logic.
//     load in any state: count<=load_val, reload_reg<=load_val, state<=IDLE.
//     start in the same cycle as load is ignored.
//   - IDLE:
//     start & count!=0 -> RUN.
//     start & count==0 -> DONE.
//     No start -> hold all values.
//   - RUN:
//     hold=1 -> count and state frozen.
//     hold=0 -> count<=dec16(count).
//     If count==1 on that edge -> state<=DONE (count becomes 0 on the same edge).
//     start is ignored in RUN.
//   - DONE:
//     AUTO_RELOAD=0 -> next edge state<=IDLE; count stays 0.
//     AUTO_RELOAD=1 -> count<=reload_reg; state<=RUN if reload_reg!=0, else stay in DONE
//     (done then stays high continuously).
//     start and hold are ignored in DONE.
//   - Latency: start sampled at edge E0 with count=N and no hold.
//     count==0 and done=1 at edge E0+N; done falls at E0+N+1.
//     N=0 gives done at E0. Each hold cycle in RUN delays done by one cycle.
//   - Arithmetic: dec16 is modulo 2^16 (0000->FFFF).
//     The FSM never decrements from 0, so count never wraps.
//     Full-range run: N=FFFF gives 65535 decrements.
// STRUCTURE
//   - Shared include hack_defs.vh:
//     ST_IDLE=2'b00, ST_RUN=2'b01, ST_DONE=2'b10 (2'b11 is illegal and recovers to IDLE);
//     constant HACK_WORD=16.
//   - Sub-module dec16:
//     purely combinational 16-bit decrementer (borrow chain, mirror of inc16).
//     Verified standalone: 0000->FFFF, 0001->0000, 0010->000F, 8000->7FFF, ABCD->ABCC.
//   - Top level: one state register, count register, reload_reg; one dec16 instance.
// TESTING
//   1. Reset: rst_n=0 mid-RUN with count=0x0040 -> count=0, busy=0, done=0
//      immediately, without waiting for a clock edge.
//   2. load 0x0003, then start -> busy for 3 cycles; count 3,2,1,0;
//      done=1 exactly one cycle at E0+3; then IDLE with count=0.
//   3. load 0x0000, then start -> done at E0 with no RUN cycles.
//      Also: load 0xFFFF -> done after exactly 65535 cycles.
//   4. load 0x0005, start, hold high for 2 cycles mid-run -> done at E0+7;
//      count frozen while hold=1.
//   5. load and start in the same cycle (load_val=0x0010) -> count=0x0010,
//      state IDLE, no run.
//      load 0x0002 during RUN -> run aborts, count=0x0002, busy=0.
//   6. AUTO_RELOAD=1, load 0x0004, start -> done pulses every 5 cycles
//      (4 RUN + 1 DONE) with count sequence 4,3,2,1,0,4,...
//      load 0 then start -> done held high continuously.

Source files
------------

// File: rtl/countdown16_pkg.sv
// Shared types and constants for the countdown16 timer.
package countdown16_pkg;

    // Native word width of the Hack datapath.
    localparam int unsigned HackWord = 16;

    // Encoding is fixed so the illegal pattern 2'b11 is well defined.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

endpackage

// File: rtl/countdown16_dec16.sv
// Purely combinational decrementer (y = a - 1, modulo 2^Width), built as a
// ripple borrow chain mirroring the Hack inc16.
module countdown16_dec16
    import countdown16_pkg::*;
#(
    parameter int unsigned Width = HackWord
) (
    input  logic [Width-1:0] a,
    output logic [Width-1:0] y
);

    logic [Width:0] borrow;

    // Borrow enters at bit 0 and ripples while bits are zero.
    always_comb begin
        borrow    = '0;
        borrow[0] = 1'b1;
        y         = '0;
        for (int i = 0; i < int'(Width); i++) begin
            y[i]        = a[i] ^ borrow[i];
            borrow[i+1] = ~a[i] & borrow[i];
        end
    end

endmodule

// File: rtl/countdown16.sv
// Loadable down-counter/timer: counts a loaded value to zero, then raises
// done. With AUTO_RELOAD set it reruns from the last loaded value, forming a
// periodic tick source.
module countdown16
    import countdown16_pkg::*;
#(
    parameter int unsigned WIDTH       = HackWord,
    parameter bit          AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             hold,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    state_e           state_q;
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] count_dec;

    countdown16_dec16 #(
        .Width (WIDTH)
    ) u_dec (
        .a (count),
        .y (count_dec)
    );

    // Single FSM: load overrides everything; busy/done track the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            count    <= '0;
            reload_q <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (load) begin
            count    <= load_val;
            reload_q <= load_val;
            state_q  <= StIdle;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (count != '0) begin
                            state_q <= StRun;
                            busy    <= 1'b1;
                        end else begin
                            state_q <= StDone;
                            done    <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (!hold) begin
                        count <= count_dec;
                        // Reaching zero on this edge ends the run.
                        if (count == WIDTH'(1)) begin
                            state_q <= StDone;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    if (!AUTO_RELOAD) begin
                        state_q <= StIdle;
                        done    <= 1'b0;
                    end else begin
                        count <= reload_q;
                        // A zero reload value parks in DONE with done held high.
                        if (reload_q != '0) begin
                            state_q <= StRun;
                            busy    <= 1'b1;
                            done    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_countdown16.sv
// Directed self-checking bench for countdown16 (both reload modes) and its
// decrementer.
module tb_countdown16;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] load_val;
    logic        start;
    logic        hold;
    logic [15:0] count;
    logic        busy;
    logic        done;
    logic [15:0] ar_count;
    logic        ar_busy;
    logic        ar_done;
    logic [15:0] dec_a;
    logic [15:0] dec_y;

    int n_cmp;
    int n_fail;

    countdown16 #(
        .WIDTH       (16),
        .AUTO_RELOAD (1'b0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .hold     (hold),
        .count    (count),
        .busy     (busy),
        .done     (done)
    );

    countdown16 #(
        .WIDTH       (16),
        .AUTO_RELOAD (1'b1)
    ) dut_ar (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .hold     (hold),
        .count    (ar_count),
        .busy     (ar_busy),
        .done     (ar_done)
    );

    countdown16_dec16 #(
        .Width (16)
    ) u_dec (
        .a (dec_a),
        .y (dec_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        load = 1'b0;
        start = 1'b0;
        hold = 1'b0;
        load_val = 16'h0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic load_value(input logic [15:0] v);
        load = 1'b1;
        load_val = v;
        tick();
        load = 1'b0;
    endtask

    task automatic test_dec();
        logic [15:0] va [5] = '{16'h0000, 16'h0001, 16'h0010, 16'h8000, 16'hABCD};
        logic [15:0] vy [5] = '{16'hFFFF, 16'h0000, 16'h000F, 16'h7FFF, 16'hABCC};
        for (int i = 0; i < 5; i++) begin
            dec_a = va[i];
            #1;
            n_cmp++;
            if (dec_y !== vy[i]) begin
                n_fail++;
                $display("FAIL dec16[%0d]: a=%h got %h want %h", i, va[i], dec_y, vy[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        load = 1'b0;
        start = 1'b0;
        hold = 1'b0;
        load_val = 16'h0;
        #1;
        n_cmp++;
        if ({count, busy, done} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_init: got count=%h busy=%b done=%b want 0/0/0", count, busy, done);
        end
        tick();
        rst_n = 1'b1;
        tick();
        load_value(16'h0040);
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (count !== 16'h0040 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_prerun: got count=%h busy=%b want 0040/1", count, busy);
        end
        // Assert reset between edges; outputs must clear without a clock.
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({count, busy, done} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_async: got count=%h busy=%b done=%b want 0/0/0", count, busy, done);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [15:0] ec [5] = '{16'd3, 16'd2, 16'd1, 16'd0, 16'd0};
        logic        eb [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic        ed [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        load_value(16'h0003);
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            start = 1'b0;
            n_cmp++;
            if (count !== ec[i] || busy !== eb[i] || done !== ed[i]) begin
                n_fail++;
                $display("FAIL basic[E0+%0d]: got count=%h busy=%b done=%b want %h/%b/%b",
                         i, count, busy, done, ec[i], eb[i], ed[i]);
            end
        end
    endtask

    task automatic test_zero();
        do_reset();
        load_value(16'h0000);
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (count !== 16'h0 || busy !== 1'b0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_done: got count=%h busy=%b done=%b want 0000/0/1", count, busy, done);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_after: got busy=%b done=%b want 0/0", busy, done);
        end
    endtask

    task automatic test_full_range();
        int cycles;
        cycles = 0;
        do_reset();
        load_value(16'hFFFF);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 70000; i++) begin
            tick();
            if (done === 1'b1) begin
                cycles = i;
                break;
            end
        end
        n_cmp++;
        if (cycles != 65535 || count !== 16'h0) begin
            n_fail++;
            $display("FAIL full_range: got done after %0d cycles count=%h want 65535/0000",
                     cycles, count);
        end
    endtask

    task automatic test_hold();
        logic        hv [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [15:0] ec [7] = '{16'd4, 16'd3, 16'd3, 16'd3, 16'd2, 16'd1, 16'd0};
        logic        ed [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        load_value(16'h0005);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            hold = hv[i];
            tick();
            n_cmp++;
            if (count !== ec[i] || done !== ed[i] || busy !== ~ed[i]) begin
                n_fail++;
                $display("FAIL hold[E0+%0d]: got count=%h busy=%b done=%b want %h/%b/%b",
                         i + 1, count, busy, done, ec[i], ~ed[i], ed[i]);
            end
        end
        hold = 1'b0;
    endtask

    task automatic test_load_priority();
        do_reset();
        load = 1'b1;
        start = 1'b1;
        load_val = 16'h0010;
        tick();
        load = 1'b0;
        start = 1'b0;
        tick();
        n_cmp++;
        if (count !== 16'h0010 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL load_start: got count=%h busy=%b done=%b want 0010/0/0", count, busy, done);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        n_cmp++;
        if (count !== 16'h000F || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL load_midrun_pre: got count=%h busy=%b want 000F/1", count, busy);
        end
        load_value(16'h0002);
        n_cmp++;
        if (count !== 16'h0002 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL load_abort: got count=%h busy=%b want 0002/0", count, busy);
        end
        tick();
        n_cmp++;
        if (count !== 16'h0002 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL load_idle: got count=%h busy=%b done=%b want 0002/0/0", count, busy, done);
        end
    endtask

    task automatic test_auto_reload();
        logic [15:0] ec [10] = '{16'd3, 16'd2, 16'd1, 16'd0, 16'd4,
                                 16'd3, 16'd2, 16'd1, 16'd0, 16'd4};
        logic        ed [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                                 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        load_value(16'h0004);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (ar_count !== ec[i] || ar_done !== ed[i] || ar_busy !== ~ed[i]) begin
                n_fail++;
                $display("FAIL auto[E0+%0d]: got count=%h busy=%b done=%b want %h/%b/%b",
                         i + 1, ar_count, ar_busy, ar_done, ec[i], ~ed[i], ed[i]);
            end
        end
        load_value(16'h0000);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (ar_done !== 1'b1 || ar_busy !== 1'b0 || ar_count !== 16'h0) begin
                n_fail++;
                $display("FAIL auto_zero[%0d]: got count=%h busy=%b done=%b want 0000/0/1",
                         i, ar_count, ar_busy, ar_done);
            end
            tick();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        dec_a = 16'h0;
        test_reset();
        test_dec();
        test_basic();
        test_zero();
        test_hold();
        test_load_priority();
        test_auto_reload();
        test_full_range();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
